// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-stage load/store path: access sizes,
// controller FSM states and the word-align mask.
package mem_access_pkg;

  localparam logic [1:0]  SZ_BYTE         = 2'b00;
  localparam logic [1:0]  SZ_HALF         = 2'b01;
  localparam logic [1:0]  SZ_WORD         = 2'b10;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extracts/extends load data from a memory word
// and merges right-justified store data into a memory word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_word,
  output logic [31:0] store_word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Load path: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    byte_s = 8'd0;
    case (lane)
      2'd0:    byte_s = old_word[7:0];
      2'd1:    byte_s = old_word[15:8];
      2'd2:    byte_s = old_word[23:16];
      2'd3:    byte_s = old_word[31:24];
      default: byte_s = 8'd0;
    endcase
    if (lane[1]) begin
      half_s = old_word[31:16];
    end else begin
      half_s = old_word[15:0];
    end
    case (size)
      SZ_BYTE: load_word = {{24{is_signed & byte_s[7]}}, byte_s};
      SZ_HALF: load_word = {{16{is_signed & half_s[15]}}, half_s};
      default: load_word = old_word;
    endcase
  end

  // Store path: overwrite only the addressed lane(s) of the old word.
  always_comb begin
    store_word = old_word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    store_word[7:0]   = store_data[7:0];
          2'd1:    store_word[15:8]  = store_data[7:0];
          2'd2:    store_word[23:16] = store_data[7:0];
          2'd3:    store_word[31:24] = store_data[7:0];
          default: store_word        = old_word;
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) begin
          store_word[31:16] = store_data[15:0];
        end else begin
          store_word[15:0] = store_data[15:0];
        end
      end
      SZ_WORD: store_word = store_data;
      default: store_word = old_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store controller: one request at a time, read-modify-write
// for sub-word stores, lane-extracted loads, and rejection of bad accesses.
module load_store_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  output logic        mem_en,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  lsu_state_e  state_r, state_next_s;
  logic [31:0] addr_r, wdata_r, hold_r;
  logic [1:0]  size_r;
  logic        signed_r, write_r;

  logic        accept_s, req_err_s;
  logic [31:0] req_base_s;
  logic [32:0] req_last_s;
  logic [31:0] align_old_s, load_word_s, store_word_s;

  assign req_ready = (state_r == ST_IDLE);
  assign accept_s  = req_valid && req_ready;

  // Acceptance-time error check; last byte computed in 33 bits so top-of-space addresses cannot wrap.
  always_comb begin
    req_base_s = req_addr & WORD_ALIGN_MASK;
    req_last_s = {1'b0, req_base_s} + 33'd3;
    req_err_s  = (req_size == 2'b11)
              || ((req_size == SZ_HALF) && req_addr[0])
              || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
              || (req_last_s >= MEM_LIMIT);
  end

  // In CAP the fresh memory word feeds the aligner directly; in WR the held copy does.
  always_comb begin
    if (state_r == ST_CAP) begin
      align_old_s = mem_rdata;
    end else begin
      align_old_s = hold_r;
    end
  end

  mem_lane_align u_align (
    .lane       (addr_r[1:0]),
    .size       (size_r),
    .is_signed  (signed_r),
    .old_word   (align_old_s),
    .store_data (wdata_r),
    .load_word  (load_word_s),
    .store_word (store_word_s)
  );

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          state_next_s = ST_IDLE;
        end else if (req_err_s) begin
          state_next_s = ST_RESP;
        end else if (req_write && (req_size == SZ_WORD)) begin
          state_next_s = ST_WR;
        end else begin
          state_next_s = ST_RD;
        end
      end
      ST_RD:   state_next_s = ST_CAP;
      ST_CAP: begin
        if (write_r) begin
          state_next_s = ST_WR;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      ST_WR:   state_next_s = ST_RESP;
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Memory port decode from the state and holding registers.
  always_comb begin
    mem_en    = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    case (state_r)
      ST_RD: begin
        mem_en   = 1'b1;
        mem_addr = addr_r & WORD_ALIGN_MASK;
      end
      ST_WR: begin
        mem_en    = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = addr_r & WORD_ALIGN_MASK;
        mem_wdata = store_word_s;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  // State, request capture, holding register and one-cycle response pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      hold_r     <= 32'd0;
      size_r     <= 2'b00;
      signed_r   <= 1'b0;
      write_r    <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      state_r    <= state_next_s;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      if (accept_s) begin
        addr_r   <= req_addr;
        wdata_r  <= req_wdata;
        size_r   <= req_size;
        signed_r <= req_signed;
        write_r  <= req_write;
      end
      if (state_r == ST_CAP) begin
        hold_r <= mem_rdata;
      end
      // Only an error enters RESP straight from IDLE; only a load enters it from CAP.
      if (state_next_s == ST_RESP) begin
        resp_valid <= 1'b1;
        resp_err   <= (state_r == ST_IDLE);
        if (state_r == ST_CAP) begin
          resp_rdata <= load_word_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural dmem plus a byte-array
// reference model; directed plan steps followed by randomized traffic.
module tb_load_store_unit;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rw, mem_en;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rw     (mem_rw),
    .mem_en     (mem_en),
    .mem_rdata  (mem_rdata)
  );

  // Behavioural dmem: registered read, shared synchronous reset clears contents.
  logic [31:0] dmem [0:MEM_BYTES/4-1];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_BYTES/4; i++) dmem[i] <= 32'd0;
      mem_rdata <= 32'd0;
    end else if (mem_en) begin
      if (mem_rw) dmem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= dmem[mem_addr[9:2]];
    end
  end

  // Reference model: little-endian byte array.
  byte unsigned ref_mem [0:MEM_BYTES-1];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] a);
    longint base;
    base = longint'({32'd0, a}) - longint'(a % 4);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
           (sz == 2'd2 && (a % 4) != 0) || (base + 3 >= MEM_BYTES);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int n;
    longint v;
    n = 1 << sz;
    v = 0;
    for (int k = 0; k < n; k++) v += longint'(ref_mem[a + k]) << (8 * k);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    for (int k = 0; k < (1 << sz); k++) ref_mem[a + k] = 8'((wd >> (8 * k)) & 32'hFF);
  endtask

  function automatic int ref_latency(input bit e, input logic w, input logic [1:0] sz);
    if (e) return 1;
    if (w && sz == 2'd2) return 2;
    if (w) return 4;
    return 3;
  endfunction

  task automatic check_mem_image(input string tag);
    int bad;
    logic [31:0] word;
    bad = 0;
    for (int i = 0; i < MEM_BYTES/4; i++) begin
      word = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
      if (dmem[i] !== word) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  // One isolated request: drives it, watches every cycle until the response, checks all timing.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    bit e;
    int lat, en_exp, got_lat, en_cnt, rw_cnt, rw_cyc, ready_bad;
    logic [31:0] rd_exp, got_rd;
    logic got_err;
    e      = ref_err(sz, a);
    lat    = ref_latency(e, w, sz);
    rd_exp = (!e && !w) ? ref_load(sz, sg, a) : 32'd0;
    en_exp = e ? 0 : ((w && sz != 2'd2) ? 2 : 1);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (w && !e) ref_store(sz, a, wd);
    got_lat = -1; en_cnt = 0; rw_cnt = 0; rw_cyc = -1; ready_bad = 0;
    got_rd = 32'hx; got_err = 1'bx;
    for (int c = 1; c <= 8 && got_lat < 0; c++) begin
      @(negedge clk);
      if (mem_en) en_cnt++;
      if (mem_rw) begin rw_cnt++; rw_cyc = c; end
      if (req_ready) ready_bad++;
      if (resp_valid) begin got_lat = c; got_rd = resp_rdata; got_err = resp_err; end
    end
    check({tag, ".latency"}, 32'(got_lat), 32'(lat));
    check({tag, ".err"}, 32'(got_err), 32'(e));
    check({tag, ".rdata"}, got_rd, rd_exp);
    check({tag, ".en_cycles"}, 32'(en_cnt), 32'(en_exp));
    check({tag, ".rw_cycles"}, 32'(rw_cnt), (w && !e) ? 32'd1 : 32'd0);
    if (w && !e) check({tag, ".rw_in_wr"}, 32'(rw_cyc), 32'(lat - 1));
    check({tag, ".ready_low"}, 32'(ready_bad), 32'd0);
    @(negedge clk);
    check({tag, ".pulse_end"}, {resp_valid, resp_err, 30'd0} | resp_rdata, 32'd0);
    check({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic rand_req(input int idx, output logic w, output logic [1:0] sz, output logic sg,
                          output logic [31:0] a, output logic [31:0] wd);
    w  = idx[0];
    sz = 2'($urandom_range(0, 2));
    if ($urandom_range(0, 9) == 0) sz = 2'd3;
    sg = 1'($urandom_range(0, 1));
    a  = 32'h40 + 32'($urandom_range(0, 63));
    if ($urandom_range(0, 7) != 0) begin
      if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
      if (sz == 2'd2) a = a & 32'hFFFF_FFFC;
    end
    wd = $urandom;
  endtask

  // req_valid held high throughout; responses matched in order against a queue.
  task automatic stream(input int n);
    logic [31:0] exp_rd_q[$];
    logic        exp_err_q[$];
    int          exp_lat_q[$];
    int          acc_q[$];
    int sent, got, cyc, last_acc, last_lat, lat, acc;
    bit e;
    logic w, sg;
    logic [1:0] sz;
    logic [31:0] a, wd;
    sent = 0; got = 0; cyc = 0; last_acc = -1; last_lat = 0;
    while (got < n && cyc < n * 8 + 20) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) begin
        if (exp_lat_q.size() == 0) begin
          check("stream.extra_resp", 32'(got + 1), 32'(n));
        end else begin
          acc = acc_q.pop_front();
          lat = exp_lat_q.pop_front();
          check("stream.rdata", resp_rdata, exp_rd_q.pop_front());
          check("stream.err", 32'(resp_err), 32'(exp_err_q.pop_front()));
          check("stream.latency", 32'(cyc - acc), 32'(lat));
        end
        got++;
      end
      if (req_ready && sent < n) begin
        if (last_acc >= 0) check("stream.b2b_gap", 32'(cyc - last_acc), 32'(last_lat + 1));
        rand_req(sent, w, sz, sg, a, wd);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        e = ref_err(sz, a);
        lat = ref_latency(e, w, sz);
        exp_rd_q.push_back((!e && !w) ? ref_load(sz, sg, a) : 32'd0);
        exp_err_q.push_back(e);
        exp_lat_q.push_back(lat);
        acc_q.push_back(cyc);
        if (w && !e) ref_store(sz, a, wd);
        last_acc = cyc; last_lat = lat;
        sent++;
      end else if (sent >= n) begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("stream.sent", 32'(sent), 32'(n));
    check("stream.responses", 32'(got), 32'(n));
  endtask

  initial begin
    logic w, sg;
    logic [1:0] sz;
    logic [31:0] a, wd;
    int got_rv;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.req_ready", 32'(req_ready), 32'd1);
    check("reset.resp", {30'd0, resp_valid, resp_err}, 32'd0);
    check("reset.resp_rdata", resp_rdata, 32'd0);
    check("reset.mem_ctl", {30'd0, mem_rw, mem_en}, 32'd0);
    check("reset.mem_addr", mem_addr, 32'd0);
    check("reset.mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    do_req("st_word", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    do_req("ld_word", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("ld_word.model", ref_load(2'd2, 1'b0, 32'h10), 32'hDEAD_BEEF);

    do_req("st_base", 1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
    do_req("st_byte", 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB);
    do_req("ld_merged", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("ld_merged.model", ref_load(2'd2, 1'b0, 32'h10), 32'h1122_AB44);

    do_req("st_ext", 1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF_7F01);
    do_req("ld_sb", 1'b0, 2'd0, 1'b1, 32'h23, 32'h0);
    do_req("ld_ub", 1'b0, 2'd0, 1'b0, 32'h23, 32'h0);
    do_req("ld_sh", 1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
    do_req("ld_uh", 1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    do_req("ld_sh_hi", 1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    do_req("st_half", 1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF_1234);

    do_req("err_half", 1'b0, 2'd1, 1'b1, 32'h21, 32'h0);
    do_req("err_word_st", 1'b1, 2'd2, 1'b0, 32'h22, 32'hFFFF_FFFF);
    do_req("err_size", 1'b1, 2'd3, 1'b0, 32'h30, 32'h5555_5555);
    do_req("err_word_ld", 1'b0, 2'd2, 1'b0, 32'h3FD, 32'h0);
    do_req("err_range", 1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    do_req("err_range_st", 1'b1, 2'd0, 1'b0, 32'h8000_0001, 32'h77);
    do_req("edge_byte", 1'b1, 2'd0, 1'b0, 32'h3FF, 32'h0000_00C3);
    do_req("edge_ld", 1'b0, 2'd0, 1'b1, 32'h3FF, 32'h0);
    check_mem_image("mem_after_errors");

    // Reset asserted while a byte store sits in WR.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h31; req_wdata = 32'h5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr.in_wr", {30'd0, mem_rw, mem_en}, 32'd3);
    reset = 1'b1;
    got_rv = 0;
    @(negedge clk);
    if (resp_valid) got_rv++;
    reset = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'd0;
    check("rst_wr.idle", 32'(req_ready), 32'd1);
    check("rst_wr.mem_en", 32'(mem_en), 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) got_rv++;
    end
    check("rst_wr.no_resp", 32'(got_rv), 32'd0);
    check_mem_image("rst_wr.mem_cleared");
    do_req("rst_wr.ld", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0);

    for (int i = 0; i < 24; i++) begin
      rand_req(i, w, sz, sg, a, wd);
      do_req("rand", w, sz, sg, a, wd);
    end

    stream(40);
    repeat (2) @(negedge clk);
    check_mem_image("mem_final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store controller sitting directly upstream of the word-wide, byte-addressed data memory (`dmem`). It accepts one load or store request at a time from the pipeline and sequences the `dmem` port. Byte and halfword stores are performed as aligned read-modify-write. Load data is lane-extracted and sign- or zero-extended, and misaligned or out-of-range accesses are rejected without touching memory.

## Interface
- MEM_BYTES, 1024: data memory size in bytes; must match `dmem` storage depth.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  reset, synchronous, active-high; clock clk.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; handshake on `req_valid && req_ready`.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal size, or out-of-range access.
- mem_addr  out  32  to `dmem` address; always word-aligned (`{req_addr[31:2],2'b00}`).
- mem_wdata  out  32  to `dmem` data_in.
- mem_rw  out  1  to `dmem` read_write; 1 only in WR.
- mem_en  out  1  to `dmem` enable; high in RD and WR.
- mem_rdata  in  32  from `dmem` dataOut; valid the cycle after RD.

## Operation
- Accepted request fields are registered: addr, size, signed, write, wdata. Lane = addr[1:0].
- Error check at acceptance: size 11; half with addr[0]=1; word with addr[1:0]≠0; aligned base+3 ≥ MEM_BYTES. Error goes to RESP with resp_err=1, rdata=0, and issues no memory access.
- FSM states: IDLE, RD, CAP, WR, RESP.
  - IDLE → RESP on error.
  - IDLE → WR on a word store.
  - IDLE → RD otherwise.
  - RD → CAP unconditionally.
  - CAP → RESP on a load.
  - CAP → WR on a byte or half store.
  - WR → RESP unconditionally.
  - RESP → IDLE unconditionally.
- RD drives mem_rw=0 and mem_addr=base. CAP latches mem_rdata into the holding register.
- Load extract:
  - Byte selects bits [8*lane+7 : 8*lane].
  - Half selects bits [16*addr[1]+15 : 16*addr[1]].
  - Extension is by the MSB when req_signed=1, else zero-fill. Word loads pass through.
- Store merge:
  - Byte replaces lane byte with wdata[7:0].
  - Half replaces the selected half with wdata[15:0].
  - Word writes wdata directly. WR drives the merged word with mem_rw=1.
- mem_* outputs are decoded combinationally from the state register and the holding registers. mem_rw=0 in every state except WR.

## Timing
- Reset values:
  - state=IDLE.
  - req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_rw=0, mem_en=0, mem_addr=0, mem_wdata=0.
- Handshake on cycle 0. resp_valid latency:
  - Error: cycle 1.
  - Word store: cycle 2.
  - Load: cycle 3.
  - Byte/half store: cycle 4.
- req_ready is low from cycle 1 through RESP. It returns high the cycle after RESP, so back-to-back accept is possible at the earliest on cycle latency+1.
- resp_valid is exactly one cycle; resp_rdata and resp_err are valid only then and are cleared to 0 otherwise.
- Reset mid-operation returns to IDLE on that edge, and no response is issued. A pending WR that coincides with reset is harmless because `dmem` shares the reset and clears.
- A store followed by a load to the same word returns the new data, since WR completes before the next RD is issued.

## Structure
- Package `mem_access_pkg` holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the FSM state enum;
  - the helper constant for the word-align mask.
- One sub-module, `mem_lane_align`, is purely combinational. It takes lane, size, signed, old word and store data, and produces the extended load word and the merged store word. It is shared by the CAP and WR paths.
- FSM, registers and error check live in `load_store_unit`.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → resp_rdata=0xDEADBEEF, err=0. Latencies are 2 and 3 cycles.
- Byte store 0xAB @0x11 over 0x11223344, then word load @0x10 → 0x1122AB44. Check the mem_rw=1 pulse only in WR.
- Memory holds 0x80FF7F01 @0x20:
  - signed byte load @0x23 → 0xFFFFFF80;
  - unsigned byte load @0x23 → 0x00000080;
  - signed half load @0x20 → 0x00007F01;
  - unsigned half load @0x22 → 0x000080FF.
- Half load @0x21, word store @0x22, size=11, word load @0x3FD → resp_err=1 at cycle 1, rdata=0. No mem_en and no memory change.
- Assert reset while in WR of a byte store → IDLE next cycle, no resp_valid, and memory reads 0.
- Hold req_valid high continuously with alternating loads/stores → req_ready pulses correctly and no request is dropped or duplicated.
